// File: rtl/calc_pkg.sv
// Shared types and constants for the calc_sched cube-root scheduler.
//   CALC_W           : operand/result width of the `calculate` unit
//   TIMEOUT_CYC_DFLT : default watchdog limit in cycles
//   sched_state_t    : scheduler FSM states
//   calc_resp_t      : response payload (error flag + result)
package calc_pkg;

  localparam int unsigned CALC_W           = 32;
  localparam int unsigned TIMEOUT_CYC_DFLT = 4096;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic              err;
    logic [CALC_W-1:0] res;
  } calc_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after ptr_i (wrapping modulo NREQ) when en_i is high.
//   req_i     : request vector
//   ptr_i     : highest-priority index (must be < NREQ)
//   en_i      : arbitration enable
//   gnt_o     : one-hot grant
//   gnt_idx_o : encoded grant index
//   gnt_any_o : some request was granted
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  logic found;

  // First pass scans [ptr, NREQ-1]; the second pass picks the lowest index,
  // which is only reached when nothing at or after ptr is requesting.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en_i && !found && req_i[i] && (IDW'(i) >= ptr_i)) begin
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IDW'(i);
        found     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en_i && !found && req_i[i]) begin
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IDW'(i);
        found     = 1'b1;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/calc_sched.sv
// Round-robin scheduler sharing one iterative cube-root unit among NREQ
// requesters, with a watchdog and a return-to-idle handshake.
//   req_valid/req_num/req_ready : per-requester operand channel
//   resp_*                      : shared response channel, held until resp_ack
//   calc_go/calc_num            : start level and operand to the unit
//   calc_ready/calc_res         : done level and result from the unit
//   busy                        : scheduler not idle
module calc_sched
  import calc_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned IDW         = 3,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [CALC_W*NREQ-1:0] req_num,
  output logic [NREQ-1:0]        req_ready,
  output logic                   resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [CALC_W-1:0]      resp_res,
  output logic                   resp_err,
  input  logic                   resp_ack,
  output logic                   calc_go,
  output logic [CALC_W-1:0]      calc_num,
  input  logic                   calc_ready,
  input  logic [CALC_W-1:0]      calc_res,
  output logic                   busy
);

  localparam int unsigned     CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t      state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [IDW-1:0]    resp_id_q, resp_id_d;
  calc_resp_t        resp_q, resp_d;
  logic              calc_go_q, calc_go_d;
  logic [CALC_W-1:0] calc_num_q, calc_num_d;
  logic              busy_q;

  logic [NREQ-1:0]   gnt_oh;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;
  logic [CALC_W-1:0] gnt_num;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (state_q == IDLE),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // One-hot mux of the granted operand.
  always_comb begin
    gnt_num = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) gnt_num |= req_num[i*CALC_W +: CALC_W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_d       = resp_q;
    calc_go_d    = calc_go_q;
    calc_num_d   = calc_num_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready_d = gnt_oh;
          calc_num_d  = gnt_num;
          resp_id_d   = gnt_idx;
          ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        calc_go_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the timeout cycle still counts as success.
        if (calc_ready) begin
          resp_d.res   = calc_res;
          resp_d.err   = 1'b0;
          resp_valid_d = 1'b1;
          calc_go_d    = 1'b0;
          state_d      = RESP;
        end else if (cnt_q == CNT_MAX) begin
          resp_d.res   = '0;
          resp_d.err   = 1'b1;
          resp_valid_d = 1'b1;
          calc_go_d    = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ack) begin
          resp_valid_d = 1'b0;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        if (!calc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_q       <= '0;
      calc_go_q    <= 1'b0;
      calc_num_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_q       <= resp_d;
      calc_go_q    <= calc_go_d;
      calc_num_q   <= calc_num_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_res   = resp_q.res;
  assign resp_err   = resp_q.err;
  assign calc_go    = calc_go_q;
  assign calc_num   = calc_num_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_calc_sched.sv
// Directed bench for calc_sched with a behavioural cube-root unit and a
// scoreboard of expected responses.
module tb_calc_sched;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 3;
  localparam int unsigned TO   = 16;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    res;
    logic           err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [32*NREQ-1:0] req_num;
  logic [NREQ-1:0]  req_ready;
  logic             resp_valid;
  logic [IDW-1:0]   resp_id;
  logic [31:0]      resp_res;
  logic             resp_err;
  logic             resp_ack;
  logic             calc_go;
  logic [31:0]      calc_num;
  logic             calc_ready;
  logic [31:0]      calc_res;
  logic             busy;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   model_lat = 10;  // 0 = unit never answers
  int   wait_cnt  = 0;
  int   cyc;

  calc_sched #(
    .NREQ        (NREQ),
    .IDW         (IDW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_num    (req_num),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_res   (resp_res),
    .resp_err   (resp_err),
    .resp_ack   (resp_ack),
    .calc_go    (calc_go),
    .calc_num   (calc_num),
    .calc_ready (calc_ready),
    .calc_res   (calc_res),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] icbrt(input logic [31:0] n);
    logic [63:0] r;
    r = '0;
    while ((r + 64'd1) * (r + 64'd1) * (r + 64'd1) <= 64'(n)) r++;
    return r[31:0];
  endfunction

  // Cube-root unit: raises ready model_lat cycles after go rises, drops it
  // on the cycle after go falls.
  initial begin
    calc_ready = 1'b0;
    calc_res   = '0;
    forever begin
      @(negedge clk);
      if (!calc_go) begin
        calc_ready = 1'b0;
        wait_cnt   = 0;
      end else if (!calc_ready) begin
        wait_cnt++;
        if (model_lat != 0 && wait_cnt >= model_lat) begin
          calc_ready = 1'b1;
          calc_res   = icbrt(calc_num);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [31:0] res, input logic err);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp_oh, input string tag);
    int n;
    n = 0;
    while (req_ready == '0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 128'(req_ready), 128'(exp_oh));
  endtask

  task automatic get_resp(input string tag, output int n);
    exp_t e;
    n = 0;
    while (!resp_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_pending"}, 128'(sb.size() != 0), 128'(1'b1));
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
    chk(tag, 128'({resp_valid, resp_id, resp_res, resp_err}),
        128'({1'b1, e.id, e.res, e.err}));
  endtask

  task automatic ack_resp(input string tag);
    resp_ack = 1'b1;
    tick();
    resp_ack = 1'b0;
    chk({tag, "_drop"}, 128'({resp_valid, busy}), 128'(2'b01));
    tick();
    chk({tag, "_idle"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_num   = '0;
    resp_ack  = 1'b0;
    #2 rst_n  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        128'({req_ready, resp_valid, resp_id, resp_res, resp_err, calc_go, calc_num, busy}),
        128'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Contention from pointer 0: grants alternate 0,1,0,1.
    model_lat = 10;
    req_num   = {32'd64, 32'd8};
    req_valid = 2'b11;
    for (int op = 0; op < 4; op++) begin
      push_exp(IDW'(op % 2), (op % 2 == 0) ? 32'd2 : 32'd4, 1'b0);
      wait_grant(NREQ'(1 << (op % 2)), "cont_grant");
      if (op == 3) req_valid = '0;
      get_resp("cont_resp", cyc);
      ack_resp("cont_ack");
    end

    // Single request: 27 -> 3, one-cycle ready pulse, go two edges after sampling.
    req_num[31:0] = 32'd27;
    req_valid     = 2'b01;
    push_exp(3'd0, 32'd3, 1'b0);
    tick();
    chk("single_grant", 128'({req_ready, calc_go, busy}), 128'({2'b01, 1'b0, 1'b1}));
    req_valid = '0;
    tick();
    chk("single_pulse", 128'({req_ready, calc_go, calc_num}), 128'({2'b00, 1'b1, 32'd27}));
    get_resp("single_resp", cyc);
    chk("single_lat", 128'(cyc), 128'(10));
    chk("single_go_low", 128'(calc_go), 128'(1'b0));
    ack_resp("single_ack");

    // Timeout: unit never answers.
    model_lat      = 0;
    req_num[63:32] = 32'd5;
    req_valid      = 2'b10;
    push_exp(3'd1, 32'd0, 1'b1);
    wait_grant(2'b10, "to_grant");
    req_valid = '0;
    tick();
    chk("to_go", 128'(calc_go), 128'(1'b1));
    get_resp("to_resp", cyc);
    chk("to_lat", 128'(cyc), 128'(TO));
    chk("to_go_low", 128'(calc_go), 128'(1'b0));
    ack_resp("to_ack");

    // Back-pressure: ack withheld 50 cycles with both requesters pending.
    model_lat     = 10;
    req_num[31:0] = 32'd125;
    req_valid     = 2'b01;
    push_exp(3'd0, 32'd5, 1'b0);
    wait_grant(2'b01, "bp_grant");
    req_valid = '0;
    get_resp("bp_resp", cyc);
    req_num   = {32'd1000, 32'd125};
    req_valid = 2'b11;
    for (int i = 0; i < 50; i++) begin
      chk("bp_hold",
          128'({resp_valid, resp_id, resp_res, resp_err, req_ready, calc_go, busy}),
          128'({1'b1, 3'd0, 32'd5, 1'b0, 2'b00, 1'b0, 1'b1}));
      tick();
    end
    // Next grant goes to requester 1 (pointer moved past 0); unit answers on
    // the timeout cycle, which must still report success.
    push_exp(3'd1, 32'd10, 1'b0);
    model_lat = TO;
    resp_ack  = 1'b1;
    tick();
    resp_ack = 1'b0;
    chk("bp_drain", 128'({req_ready, resp_valid, busy}), 128'({2'b00, 1'b0, 1'b1}));
    tick();
    chk("bp_idle", 128'({req_ready, busy}), 128'({2'b00, 1'b0}));
    tick();
    chk("bp_next_grant", 128'(req_ready), 128'(2'b10));
    req_valid = '0;
    tick();
    chk("same_go", 128'({calc_go, calc_num}), 128'({1'b1, 32'd1000}));
    get_resp("same_resp", cyc);
    chk("same_lat", 128'(cyc), 128'(TO));
    ack_resp("same_ack");

    // Reset in WAIT: silent abort, pointer back to 0.
    model_lat     = 0;
    req_num[31:0] = 32'd8;
    req_valid     = 2'b01;
    wait_grant(2'b01, "rst_grant");
    req_valid = '0;
    repeat (4) tick();
    chk("rst_pre", 128'({busy, calc_go}), 128'(2'b11));
    req_num   = {32'd64, 32'd27};
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async",
        128'({req_ready, resp_valid, resp_id, resp_res, resp_err, calc_go, calc_num, busy}),
        128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_silent", 128'({resp_valid, 1'(sb.size() != 0)}), 128'(2'b00));
    model_lat = 3;
    push_exp(3'd0, 32'd3, 1'b0);
    wait_grant(2'b01, "rst_first");
    req_valid = 2'b10;
    push_exp(3'd1, 32'd4, 1'b0);
    get_resp("rst_resp0", cyc);
    ack_resp("rst_ack0");
    wait_grant(2'b10, "rst_second");
    req_valid = '0;
    get_resp("rst_resp1", cyc);
    ack_resp("rst_ack1");
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
